gate_logic_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit: WIDTH-bit operands a/b, 3-bit op selects one of the eight

---
 rtl/gate_ops_pkg.sv | 15 +
 rtl/gate_eval.sv | 32 +++
 rtl/gate_logic_pipe.sv | 96 +++++++++
 tb/tb_gate_logic_pipe.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/gate_ops_pkg.sv
// Shared op encodings for the pipelined bitwise logic unit.
//   OP_W        width of the function-select field
//   OP_AND..    3-bit codes for the eight two-input functions
package gate_ops_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOTA = 3'd2;
  localparam logic [OP_W-1:0] OP_NOTB = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd7;
endpackage

// File: rtl/gate_eval.sv
// Combinational evaluator: applies one of eight bitwise functions to a/b.
//   op   in  OP_W   function select
//   a    in  WIDTH  operand A
//   b    in  WIDTH  operand B
//   res  out WIDTH  bitwise result
module gate_eval
  import gate_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOTA: res = ~a;
      OP_NOTB: res = ~b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/gate_logic_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// S1 holds op/a/b, S2 holds the evaluated result plus its flags and drives
// the outputs. Full throughput: a stage reloads whenever the stage after it
// is moving, so no bubbles are inserted under continuous flow.
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        operand handshake
//   in_op, in_a, in_b        function select and operands
//   out_valid/out_ready      result handshake
//   out_res                  result
//   out_zero/parity/ones     flags of out_res
//   op_count                 consumed-result counter (wraps)
module gate_logic_pipe
  import gate_ops_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_ones,
  output logic [CNT_W-1:0] op_count
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic [OP_W-1:0]  s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH-1:0] s2_res, eval_res;
  logic             s2_zero, s2_parity, s2_ones;
  logic [CNT_W-1:0] cnt_q;
  logic             s1_load, s2_load;

  assign s2_load  = !vld_pipe[2] || out_ready;
  assign s1_load  = !vld_pipe[1] || s2_load;
  assign in_ready = s1_load;

  gate_eval #(.WIDTH(WIDTH)) u_eval (
    .op  (s1_op),
    .a   (s1_a),
    .b   (s1_b),
    .res (eval_res)
  );

  // Payload of S1 carries no reset; its valid bit guards it.
  always_ff @(posedge clk) begin
    if (in_valid && s1_load) begin
      s1_op <= in_op;
      s1_a  <= in_a;
      s1_b  <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s2_res    <= '0;
      s2_zero   <= 1'b0;
      s2_parity <= 1'b0;
      s2_ones   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (s1_load) vld_pipe[1] <= in_valid;
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        // Flags registered alongside the result so they can never disagree.
        if (vld_pipe[1]) begin
          s2_res    <= eval_res;
          s2_zero   <= ~|eval_res;
          s2_parity <= ^eval_res;
          s2_ones   <= &eval_res;
        end
      end
      if (vld_pipe[2] && out_ready)
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid  = vld_pipe[2];
  assign out_res    = s2_res;
  assign out_zero   = s2_zero;
  assign out_parity = s2_parity;
  assign out_ones   = s2_ones;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_gate_logic_pipe.sv
module tb_gate_logic_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [7:0]  in_a, in_b;
  logic        out_valid, out_ready;
  logic [7:0]  out_res;
  logic        out_zero, out_parity, out_ones;
  logic [15:0] op_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  gate_logic_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_zero(out_zero), .out_parity(out_parity),
    .out_ones(out_ones), .op_count(op_count)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 3'd0; in_a = 8'h00; in_b = 8'h00;
    #1;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nvec++; if (out_res !== 8'h00) begin nerr++; $display("FAIL reset_out_res got %h want 00", out_res); end
    nvec++; if ({out_zero, out_parity, out_ones} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b want 000", {out_zero, out_parity, out_ones}); end
    nvec++; if (op_count !== 16'h0000) begin nerr++; $display("FAIL reset_op_count got %h want 0000", op_count); end
    @(negedge clk); rst_n = 1'b1; #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_truth_sweep();
    logic [7:0] exp [8] = '{8'h30, 8'hFC, 8'h0F, 8'hC3, 8'hCF, 8'h03, 8'hCC, 8'h33};
    out_ready = 1'b1; in_a = 8'hF0; in_b = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin in_valid = 1'b1; in_op = 3'(i); end
      else in_valid = 1'b0;
      tick();
      // Beat i is sampled at this edge; its result shows after the next one.
      if (i >= 1 && i <= 8) begin
        nvec++; if (out_valid !== 1'b1 || out_res !== exp[i-1]) begin
          nerr++; $display("FAIL truth_op%0d got v=%b res=%h want v=1 res=%h", i-1, out_valid, out_res, exp[i-1]);
        end
      end
    end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL truth_drain got out_valid=%b want 0", out_valid); end
    nvec++; if (op_count !== 16'd8) begin nerr++; $display("FAIL truth_op_count got %0d want 8", op_count); end
  endtask

  task automatic issue_one(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    issue_one(3'd0, 8'hAA, 8'h55);
    nvec++; if ({out_valid, out_res, out_zero, out_parity, out_ones} !== {1'b1, 8'h00, 3'b100}) begin
      nerr++; $display("FAIL flags_and got v=%b res=%h z=%b p=%b o=%b want 1 00 1 0 0", out_valid, out_res, out_zero, out_parity, out_ones);
    end
    issue_one(3'd1, 8'hAA, 8'h55);
    nvec++; if ({out_valid, out_res, out_zero, out_parity, out_ones} !== {1'b1, 8'hFF, 3'b001}) begin
      nerr++; $display("FAIL flags_or got v=%b res=%h z=%b p=%b o=%b want 1 FF 0 0 1", out_valid, out_res, out_zero, out_parity, out_ones);
    end
    issue_one(3'd3, 8'h01, 8'hFF);
    nvec++; if ({out_valid, out_res, out_zero, out_parity, out_ones} !== {1'b1, 8'h00, 3'b100}) begin
      nerr++; $display("FAIL flags_notb got v=%b res=%h z=%b p=%b o=%b want 1 00 1 0 0", out_valid, out_res, out_zero, out_parity, out_ones);
    end
    issue_one(3'd1, 8'h07, 8'h00);
    nvec++; if ({out_valid, out_res, out_zero, out_parity, out_ones} !== {1'b1, 8'h07, 3'b010}) begin
      nerr++; $display("FAIL flags_parity got v=%b res=%h z=%b p=%b o=%b want 1 07 0 1 0", out_valid, out_res, out_zero, out_parity, out_ones);
    end
    tick();
    nvec++; if (op_count !== 16'd12) begin nerr++; $display("FAIL flags_op_count got %0d want 12", op_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4] = '{8'h30, 8'hFC, 8'h0F, 8'hC3};
    int sidx, ridx;
    logic acc, con;
    out_ready = 1'b0; in_a = 8'hF0; in_b = 8'h3C;
    in_valid = 1'b1; in_op = 3'd0;
    tick();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_one_in_flight in_ready got %b want 1", in_ready); end
    in_op = 3'd1;
    tick();
    nvec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      nerr++; $display("FAIL bp_full got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    in_op = 3'd2;
    for (int c = 0; c < 5; c++) begin
      tick();
      nvec++; if (out_res !== 8'h30 || out_valid !== 1'b1 || in_ready !== 1'b0 || out_zero !== 1'b0) begin
        nerr++; $display("FAIL bp_hold%0d got res=%h v=%b rdy=%b want 30 1 0", c, out_res, out_valid, in_ready);
      end
    end
    out_ready = 1'b1; #1;
    sidx = 2; ridx = 0;
    for (int c = 0; c < 20 && ridx < 4; c++) begin
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
        nvec++; if (out_res !== exp[ridx]) begin
          nerr++; $display("FAIL bp_order%0d got %h want %h", ridx, out_res, exp[ridx]);
        end
        ridx++;
      end
      tick();
      if (acc) begin
        sidx++;
        if (sidx < 4) in_op = 3'(sidx);
        else in_valid = 1'b0;
      end
    end
    nvec++; if (ridx !== 4) begin nerr++; $display("FAIL bp_count got %0d results want 4", ridx); end
    nvec++; if (out_valid !== 1'b0 || op_count !== 16'd16) begin
      nerr++; $display("FAIL bp_no_dup got v=%b op_count=%0d want 0 16", out_valid, op_count);
    end
  endtask

  task automatic test_midflight_reset();
    out_ready = 1'b0; in_a = 8'hF0; in_b = 8'h3C;
    in_valid = 1'b1; in_op = 3'd6;
    tick();
    in_op = 3'd7;
    tick();
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1 || out_res !== 8'hCC) begin
      nerr++; $display("FAIL mid_pre got v=%b res=%h want 1 CC", out_valid, out_res);
    end
    #2 rst_n = 1'b0; #1;
    nvec++; if (out_valid !== 1'b0 || out_res !== 8'h00 || op_count !== 16'h0000) begin
      nerr++; $display("FAIL mid_async got v=%b res=%h cnt=%h want 0 00 0000", out_valid, out_res, op_count);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      nvec++; if (out_valid !== 1'b0 || op_count !== 16'h0000) begin
        nerr++; $display("FAIL mid_stale%0d got v=%b cnt=%h want 0 0000", c, out_valid, op_count);
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    nvec++; if (op_count !== 16'hFFFF) begin nerr++; $display("FAIL wrap_preset got %h want FFFF", op_count); end
    out_ready = 1'b1;
    issue_one(3'd6, 8'h0F, 8'hFF);
    nvec++; if (out_res !== 8'hF0 || op_count !== 16'hFFFF) begin
      nerr++; $display("FAIL wrap_res got res=%h cnt=%h want F0 FFFF", out_res, op_count);
    end
    tick();
    nvec++; if (op_count !== 16'h0000) begin nerr++; $display("FAIL wrap got %h want 0000", op_count); end
  endtask

  initial begin
    test_reset();
    test_truth_sweep();
    test_flags();
    test_backpressure();
    test_midflight_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
